// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding uart_send: producers push at any rate, an FSM drains one byte per
// start_send/ready handshake and flags dropped writes and unacknowledged sends.
module uart_tx_feeder #(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    wr_data,
   input  logic          wr_en,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          ack_err,
   output logic          busy,
   output logic [7:0]    data_byte,
   output logic          start_send,
   input  logic          ready
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [7:0]      r_mem [DEPTH];
   logic [AW:0]     r_wr_ptr;
   logic [AW:0]     r_rd_ptr;
   logic [7:0]      r_data_byte;
   logic            r_start_send;
   logic            r_overflow;
   logic            r_ack_err;
   logic [TW-1:0]   r_to_cnt;
   logic [TW-1:0]   w_to_cnt_next;
   logic [AW:0]     w_count;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_start_next;
   logic            w_ack_set;

   // Pointers carry one extra wrap bit so occupancy is a plain subtraction.
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_full  = (w_count == (AW+1)'(DEPTH));
   assign w_empty = (w_count == '0);
   assign w_push  = wr_en && !w_full;

   assign full       = w_full;
   assign empty      = w_empty;
   assign count      = w_count;
   assign overflow   = r_overflow;
   assign ack_err    = r_ack_err;
   assign busy       = (r_state != S_IDLE) || !w_empty;
   assign data_byte  = r_data_byte;
   assign start_send = r_start_send;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next  = r_state;
      w_start_next  = 1'b0;
      w_pop         = 1'b0;
      w_to_cnt_next = r_to_cnt;
      w_ack_set     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && ready) begin
               w_pop         = 1'b1;
               w_start_next  = 1'b1;
               w_to_cnt_next = '0;
               w_state_next  = S_START;
            end
         end
         S_START: begin
            // ready falling is the acceptance; it wins even on the last timeout cycle
            if (!ready) begin
               w_state_next = S_WAIT_DONE;
            end else if (r_to_cnt == TO_LAST) begin
               w_ack_set    = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_start_next  = 1'b1;
               w_to_cnt_next = r_to_cnt + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (ready)
               w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_data_byte  <= 8'h00;
         r_start_send <= 1'b0;
         r_overflow   <= 1'b0;
         r_ack_err    <= 1'b0;
         r_to_cnt     <= '0;
      end else begin
         r_start_send <= w_start_next;
         r_to_cnt     <= w_to_cnt_next;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_data_byte <= r_mem[r_rd_ptr[AW-1:0]];
         end
         if (wr_en && w_full)
            r_overflow <= 1'b1;
         if (w_ack_set)
            r_ack_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a hand-driven ready line plays the part of uart_send.
module tb_uart_tx_feeder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] wr_data = 8'h00;
   logic       wr_en = 1'b0;
   logic       ready = 1'b0;
   logic       full, empty, overflow, ack_err, busy, start_send;
   logic [4:0] count;
   logic [7:0] data_byte;

   int   total = 0;
   int   bad = 0;
   int   starts = 0;
   logic start_q = 1'b0;

   uart_tx_feeder #(.DEPTH(16), .AW(4), .ACK_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .ack_err(ack_err), .busy(busy), .data_byte(data_byte),
      .start_send(start_send), .ready(ready)
   );

   always #5 clk = ~clk;

   // Counts rising edges of start_send, i.e. distinct send requests.
   always @(posedge clk) begin
      if (start_send && !start_q)
         starts <= starts + 1;
      start_q <= start_send;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      wr_data = v;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wait_start();
      for (int i = 0; i < 60; i++) begin
         if (start_send) break;
         step();
      end
      chk("start_seen", {31'd0, start_send}, 32'd1);
   endtask

   // One uart_send acceptance: wait for the request, check the byte, hold ready low.
   task automatic handshake(input string tag, input logic [7:0] exp, input int low);
      wait_start();
      chk(tag, {24'd0, data_byte}, {24'd0, exp});
      ready = 1'b0;
      step();
      for (int i = 1; i < low; i++) step();
      ready = 1'b1;
      step();
   endtask

   initial begin
      int s0;
      int n;

      // reset state
      step();
      chk("rst_start", {31'd0, start_send}, 32'd0);
      chk("rst_data", {24'd0, data_byte}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_count", {27'd0, count}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_ackerr", {31'd0, ack_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      ready = 1'b1;
      step();

      // single byte latency
      push(8'h70);
      chk("single_count1", {27'd0, count}, 32'd1);
      chk("single_nofall", {31'd0, start_send}, 32'd0);
      step();
      chk("single_start", {31'd0, start_send}, 32'd1);
      chk("single_data", {24'd0, data_byte}, 32'h70);
      chk("single_count0", {27'd0, count}, 32'd0);
      chk("single_busy", {31'd0, busy}, 32'd1);
      step();
      step();
      chk("single_hold", {31'd0, start_send}, 32'd1);
      ready = 1'b0;
      step();
      chk("single_drop", {31'd0, start_send}, 32'd0);
      chk("single_busy_wait", {31'd0, busy}, 32'd1);
      ready = 1'b1;
      step();
      chk("single_idle", {31'd0, busy}, 32'd0);

      // burst order with slow acceptance
      ready = 1'b0;
      for (int i = 1; i <= 5; i++) push(8'(i));
      chk("burst_count5", {27'd0, count}, 32'd5);
      s0 = starts;
      ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         wait_start();
         chk("burst_count", {27'd0, count}, 32'(5 - i));
         handshake("burst_data", 8'(i), 20);
      end
      chk("burst_starts", 32'(starts - s0), 32'd5);
      chk("burst_idle", {31'd0, busy}, 32'd0);

      // full and overflow
      ready = 1'b0;
      for (int i = 1; i <= 16; i++) push(8'(i));
      chk("full_flag", {31'd0, full}, 32'd1);
      chk("full_count", {27'd0, count}, 32'd16);
      chk("full_noovf", {31'd0, overflow}, 32'd0);
      push(8'd17);
      chk("ovf_flag", {31'd0, overflow}, 32'd1);
      chk("ovf_count", {27'd0, count}, 32'd16);
      ready = 1'b1;
      for (int i = 1; i <= 16; i++) handshake("drain_data", 8'(i), 2);
      for (int i = 0; i < 5; i++) step();
      chk("drain_nostart", {31'd0, start_send}, 32'd0);
      chk("drain_empty", {31'd0, empty}, 32'd1);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // simultaneous push and pop at count 3
      ready = 1'b0;
      push(8'h31);
      push(8'h32);
      push(8'h33);
      chk("sim_count3", {27'd0, count}, 32'd3);
      wr_data = 8'h34;
      wr_en   = 1'b1;
      ready   = 1'b1;
      step();
      wr_en   = 1'b0;
      chk("sim_count_hold", {27'd0, count}, 32'd3);
      chk("sim_data", {24'd0, data_byte}, 32'h31);
      handshake("sim_d31", 8'h31, 1);
      handshake("sim_d32", 8'h32, 1);
      handshake("sim_d33", 8'h33, 1);
      handshake("sim_d34", 8'h34, 1);

      // wrap-around over 40 bytes
      for (int b = 0; b < 4; b++) begin
         ready = 1'b0;
         for (int k = 0; k < 10; k++) push(8'(8'h40 + b * 10 + k));
         ready = 1'b1;
         for (int k = 0; k < 10; k++) handshake("wrap_data", 8'(8'h40 + b * 10 + k), 1);
      end
      chk("wrap_empty", {31'd0, empty}, 32'd1);

      // acknowledge timeout
      ready = 1'b0;
      push(8'hAA);
      push(8'hBB);
      ready = 1'b1;
      wait_start();
      chk("to_data", {24'd0, data_byte}, 32'hAA);
      n = 1;
      for (int i = 0; i < 400; i++) begin
         step();
         if (start_send) n++;
         else break;
      end
      chk("to_cycles", 32'(n), 32'd255);
      chk("to_ackerr", {31'd0, ack_err}, 32'd1);
      step();
      chk("to_next_start", {31'd0, start_send}, 32'd1);
      chk("to_next_data", {24'd0, data_byte}, 32'hBB);
      push(8'hCC);
      chk("to_count", {27'd0, count}, 32'd1);

      // asynchronous reset while start_send is high
      chk("mid_pre_start", {31'd0, start_send}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_start", {31'd0, start_send}, 32'd0);
      chk("mid_count", {27'd0, count}, 32'd0);
      chk("mid_empty", {31'd0, empty}, 32'd1);
      chk("mid_ovf", {31'd0, overflow}, 32'd0);
      chk("mid_ackerr", {31'd0, ack_err}, 32'd0);
      chk("mid_data", {24'd0, data_byte}, 32'd0);
      step();
      rst = 1'b0;
      step();
      step();
      chk("post_start", {31'd0, start_send}, 32'd0);
      chk("post_busy", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
